// File: rtl/ramb4_s8_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ramb4_s8_port_arbiter_pkg
// Shared definitions for the port-A arbiter of a 512x8 dual-port block RAM:
//   - state_t    : arbiter FSM encoding (ST_IDLE arbitrates, ST_CLEAR sweeps)
//   - RAM_DEPTH  : number of bytes in the RAM, i.e. length of a clear sweep
//   - RID_W      : width of a requester index (covers up to 8 requesters)
//   - rr_next()  : round-robin pointer advance past a winner
// ---------------------------------------------------------------------------
package ramb4_s8_port_arbiter_pkg;

  localparam int RAM_DEPTH = 512;
  localparam int RID_W     = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Pointer for the next arbitration round: one past the winner, wrapping
  // from the last requester back to requester 0.
  function automatic logic [RID_W-1:0] rr_next(input logic [RID_W-1:0] w,
                                               input int nreq);
    if (int'(w) >= nreq - 1) begin
      return '0;
    end
    return w + RID_W'(1);
  endfunction

endpackage

// File: rtl/ramb4_s8_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ramb4_s8_port_arbiter_if
// Requester-side bus of the port-A arbiter.
//   req       requester -> arbiter  per-requester access request (held)
//   req_we    requester -> arbiter  per-requester write enable
//   req_addr  requester -> arbiter  packed addresses, slice i = [i*AW +: AW]
//   req_di    requester -> arbiter  packed write data, slice i = [i*DW +: DW]
//   gnt       arbiter -> requester  one-hot combinational grant
//   rvalid    arbiter -> requester  read data valid
//   rid       arbiter -> requester  requester owning rdata
//   rdata     arbiter -> requester  read data straight from the RAM
// modport master : the requester side, modport slave : the arbiter side.
// ---------------------------------------------------------------------------
interface ramb4_s8_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 9,
  parameter int DW   = 8
);
  import ramb4_s8_port_arbiter_pkg::*;

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_di;
  logic [NREQ-1:0]    gnt;
  logic               rvalid;
  logic [RID_W-1:0]   rid;
  logic [DW-1:0]      rdata;

  modport master (
    output req, req_we, req_addr, req_di,
    input  gnt, rvalid, rid, rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_di,
    output gnt, rvalid, rid, rdata
  );

endinterface

// File: rtl/ramb4_s8_port_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ramb4_s8_port_arbiter_rr_arbiter
// Purely combinational round-robin pick: the first asserted req bit found
// searching upward from ptr, wrapping NREQ-1 -> 0.
//   req     in   NREQ   request vector
//   ptr     in   RID_W  highest-priority index for this cycle
//   gnt     out  NREQ   one-hot grant (all zero when req is zero)
//   winner  out  RID_W  index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module ramb4_s8_port_arbiter_rr_arbiter
  import ramb4_s8_port_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [RID_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [RID_W-1:0] winner
);

  int   pos;
  logic found;

  // Walk the NREQ priority slots starting at ptr; the inner loop maps the
  // rotated slot back onto a constant bit index so no variable bit-select
  // of req is needed.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    pos    = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (i == pos) && req[i]) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          winner = RID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ramb4_s8_port_arbiter.sv
// ---------------------------------------------------------------------------
// ramb4_s8_port_arbiter
// Shares port A of a 512x8 dual-port block RAM between NREQ requesters
// (round-robin, one access per cycle) and runs a clear sequencer that fills
// every byte with a constant. Port B of the RAM is not touched.
//   clk       in   1      single clock, also clocks RAM port A
//   rst_n     in   1      asynchronous active-low reset
//   bus       slave       requester bus (req/we/addr/di in, gnt/rvalid/rid/rdata out)
//   clr       in   1      one-cycle pulse starting a clear sweep
//   clr_val   in   DW     fill byte, captured on the clr cycle
//   busy      out  1      clear sweep in progress
//   ram_en    out  1      RAM ENA (registered)
//   ram_we    out  1      RAM WEA (registered)
//   ram_addr  out  AW     RAM ADDRA (registered)
//   ram_di    out  DW     RAM DIA (registered)
//   ram_do    in   DW     RAM DOA
// Timing: a request accepted in cycle t drives the RAM command during t+1;
// read data is returned with rvalid/rid during t+2.
// ---------------------------------------------------------------------------
module ramb4_s8_port_arbiter
  import ramb4_s8_port_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 9,
  parameter int DW   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ramb4_s8_port_arbiter_if.slave  bus,
  input  logic                    clr,
  input  logic [DW-1:0]           clr_val,
  output logic                    busy,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [AW-1:0]           ram_addr,
  output logic [DW-1:0]           ram_di,
  input  logic [DW-1:0]           ram_do
);

  state_t           state_reg;
  logic [RID_W-1:0] rr_ptr_reg;
  logic [AW-1:0]    sweep_cnt_reg;
  logic [DW-1:0]    fill_reg;
  logic             busy_reg;
  logic             ram_en_reg;
  logic             ram_we_reg;
  logic [AW-1:0]    ram_addr_reg;
  logic [DW-1:0]    ram_di_reg;
  logic             rv_s1_reg;
  logic             rv_s2_reg;
  logic [RID_W-1:0] rid_s1_reg;
  logic [RID_W-1:0] rid_s2_reg;

  logic [NREQ-1:0]  arb_gnt;
  logic [RID_W-1:0] arb_winner;
  logic [NREQ-1:0]  gnt_int;
  logic             accept;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_di;

  logic [AW-1:0]    addr_arr [NREQ];
  logic [DW-1:0]    di_arr   [NREQ];

  // Unpack the flat requester buses into per-requester arrays.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign addr_arr[gi] = bus.req_addr[gi*AW +: AW];
      assign di_arr[gi]   = bus.req_di[gi*DW +: DW];
    end
  endgenerate

  ramb4_s8_port_arbiter_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req    (bus.req),
    .ptr    (rr_ptr_reg),
    .gnt    (arb_gnt),
    .winner (arb_winner)
  );

  // Grants exist only while arbitrating; a clr pulse in IDLE pre-empts the
  // arbiter for that cycle so the sweep can start cleanly.
  assign gnt_int = (state_reg == ST_IDLE && !clr) ? arb_gnt : '0;
  assign accept  = |gnt_int;

  // One-hot grant -> select the winner's command fields.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_di   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_int[i]) begin
        sel_we   = bus.req_we[i];
        sel_addr = addr_arr[i];
        sel_di   = di_arr[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      sweep_cnt_reg <= '0;
      fill_reg      <= '0;
      busy_reg      <= 1'b0;
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_di_reg    <= '0;
      rv_s1_reg     <= 1'b0;
      rv_s2_reg     <= 1'b0;
      rid_s1_reg    <= '0;
      rid_s2_reg    <= '0;
    end else begin
      // Read-return pipeline runs in every state so reads issued before a
      // clear still come back.
      rv_s1_reg  <= 1'b0;
      rid_s1_reg <= arb_winner;
      rv_s2_reg  <= rv_s1_reg;
      rid_s2_reg <= rid_s1_reg;

      case (state_reg)
        ST_IDLE: begin
          if (clr) begin
            state_reg     <= ST_CLEAR;
            sweep_cnt_reg <= '0;
            fill_reg      <= clr_val;
            busy_reg      <= 1'b1;
            ram_en_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
          end else if (accept) begin
            ram_en_reg   <= 1'b1;
            ram_we_reg   <= sel_we;
            ram_addr_reg <= sel_addr;
            ram_di_reg   <= sel_di;
            rv_s1_reg    <= ~sel_we;
            rr_ptr_reg   <= rr_next(arb_winner, NREQ);
          end else begin
            ram_en_reg <= 1'b0;
            ram_we_reg <= 1'b0;
          end
        end

        ST_CLEAR: begin
          // One fill write per cycle; further clr pulses are ignored here.
          ram_en_reg    <= 1'b1;
          ram_we_reg    <= 1'b1;
          ram_addr_reg  <= sweep_cnt_reg;
          ram_di_reg    <= fill_reg;
          sweep_cnt_reg <= sweep_cnt_reg + AW'(1);
          if (sweep_cnt_reg == AW'(RAM_DEPTH - 1)) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_int;
  assign bus.rvalid = rv_s2_reg;
  assign bus.rid    = rid_s2_reg;
  assign bus.rdata  = ram_do;

  assign busy     = busy_reg;
  assign ram_en   = ram_en_reg;
  assign ram_we   = ram_we_reg;
  assign ram_addr = ram_addr_reg;
  assign ram_di   = ram_di_reg;

endmodule
